// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix datapath: FSM states, RGB444 field layout
// and default geometry.
package led_matrix_pkg;

  localparam int DEF_COLS  = 64;
  localparam int DEF_COL_W = 6;
  localparam int DEF_ROW_W = 5;
  localparam int PWM_W     = 4;
  localparam int CH_W      = 4;

  // RGB444 field positions within one 12-bit half-word
  localparam int R_LO = 8;
  localparam int R_HI = R_LO + CH_W - 1;
  localparam int G_LO = 4;
  localparam int G_HI = G_LO + CH_W - 1;
  localparam int B_LO = 0;
  localparam int B_HI = B_LO + CH_W - 1;
  localparam int UPPER_BASE = 12;
  localparam int LOWER_BASE = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREFETCH = 3'd1,
    S_SETUP    = 3'd2,
    S_CLKHI    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Channel index 0..5 = upper R,G,B then lower R,G,B; returns the LSB position in the RAM word.
  function automatic int chan_pos(input int idx);
    int base;
    int ofs;
    base = (idx < 3) ? UPPER_BASE : LOWER_BASE;
    case (idx % 3)
      0:       ofs = R_LO;
      1:       ofs = G_LO;
      default: ofs = B_LO;
    endcase
    return base + ofs;
  endfunction

endpackage

// File: rtl/led_line_shifter_if.sv
// Line request/acknowledge handshake between the row/PWM sequencer and the line shifter.
interface led_line_shifter_if
  import led_matrix_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W
);
  logic             next_line_begin;
  logic [ROW_W-1:0] next_line_addr;
  logic [PWM_W-1:0] next_line_pwm;
  logic             next_line_done;

  modport master (
    output next_line_begin,
    output next_line_addr,
    output next_line_pwm,
    input  next_line_done
  );

  modport slave (
    input  next_line_begin,
    input  next_line_addr,
    input  next_line_pwm,
    output next_line_done
  );
endinterface

// File: rtl/led_gamma_lut.sv
// Fixed 16-entry perceptual gamma curve for one 4-bit channel (used with LED_LINE_GAMMA_EN).
module led_gamma_lut (
  input  logic [3:0] level,
  output logic [3:0] gamma
);
  always_comb begin
    gamma = 4'd0;
    case (level)
      4'd0:  gamma = 4'd0;
      4'd1:  gamma = 4'd0;
      4'd2:  gamma = 4'd0;
      4'd3:  gamma = 4'd1;
      4'd4:  gamma = 4'd1;
      4'd5:  gamma = 4'd1;
      4'd6:  gamma = 4'd2;
      4'd7:  gamma = 4'd2;
      4'd8:  gamma = 4'd3;
      4'd9:  gamma = 4'd4;
      4'd10: gamma = 4'd5;
      4'd11: gamma = 4'd6;
      4'd12: gamma = 4'd8;
      4'd13: gamma = 4'd10;
      4'd14: gamma = 4'd12;
      default: gamma = 4'd15;
    endcase
  end
endmodule

// File: rtl/led_line_shifter.sv
// HUB75 line shifter: fetches a row pair, PWM-compares each channel and shifts it out.
// Optional gamma correction before the compare with `define LED_LINE_GAMMA_EN.
module led_line_shifter
  import led_matrix_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic                   clk_25MHz,
  input  logic                   rst,
  led_line_shifter_if.slave      line,
  output logic [ROW_W+COL_W-1:0] ram_addr,
  input  logic [23:0]            ram_rdata,
  output logic                   sclk,
  output logic [2:0]             rgb1,
  output logic [2:0]             rgb2
);

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [PWM_W-1:0] pwm;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;
  logic             last_col;
  logic [5:0]       lit;

  assign col_nxt  = col + COL_W'(1);
  assign last_col = (col == COL_W'(COLS - 1));

  // lit[5:3] = upper {R,G,B}, lit[2:0] = lower {R,G,B}
  for (genvar i = 0; i < 6; i++) begin : g_ch
    logic [CH_W-1:0] raw;
    logic [CH_W-1:0] lvl;
    assign raw = ram_rdata[chan_pos(i) +: CH_W];
`ifdef LED_LINE_GAMMA_EN
    led_gamma_lut u_lut (
      .level (raw),
      .gamma (lvl)
    );
`else
    assign lvl = raw;
`endif
    assign lit[5-i] = (lvl > pwm);
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      row                 <= '0;
      pwm                 <= '0;
      col                 <= '0;
      ram_addr            <= '0;
      sclk                <= 1'b0;
      rgb1                <= 3'b000;
      rgb2                <= 3'b000;
      line.next_line_done <= 1'b0;
    end else begin
      line.next_line_done <= 1'b0;
      case (state)
        // Begin arriving in the done cycle is dropped so the next line starts one cycle later
        S_IDLE: begin
          if (line.next_line_begin && !line.next_line_done) begin
            row      <= line.next_line_addr;
            pwm      <= line.next_line_pwm;
            col      <= '0;
            ram_addr <= {line.next_line_addr, COL_W'(0)};
            state    <= S_PREFETCH;
          end
        end
        S_PREFETCH: state <= S_SETUP;
        S_SETUP: begin
          rgb1 <= lit[5:3];
          rgb2 <= lit[2:0];
          sclk <= 1'b0;
          if (!last_col) ram_addr <= {row, col_nxt};
          state <= S_CLKHI;
        end
        S_CLKHI: begin
          sclk <= 1'b1;
          if (last_col) begin
            state <= S_DONE;
          end else begin
            col   <= col_nxt;
            state <= S_SETUP;
          end
        end
        S_DONE: begin
          sclk                <= 1'b0;
          line.next_line_done <= 1'b1;
          state               <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_line_shifter.sv
// Directed bench for led_line_shifter with a 1-cycle-latency framebuffer model.
module tb_led_line_shifter;
  localparam int COLS  = 64;
  localparam int COL_W = 6;
  localparam int ROW_W = 5;
  localparam int AW    = ROW_W + COL_W;

  logic          clk_25MHz = 1'b0;
  logic          rst       = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [23:0]   ram_rdata;
  logic          sclk;
  logic [2:0]    rgb1;
  logic [2:0]    rgb2;
  logic [23:0]   mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  led_line_shifter_if #(.ROW_W(ROW_W)) line ();

  led_line_shifter #(.COLS(COLS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk_25MHz (clk_25MHz),
    .rst       (rst),
    .line      (line),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .sclk      (sclk),
    .rgb1      (rgb1),
    .rgb2      (rgb2)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  always @(posedge clk_25MHz) ram_rdata <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gam(input logic [3:0] v);
`ifdef LED_LINE_GAMMA_EN
    logic [3:0] tbl [16] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
                             4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15};
    return tbl[v];
`else
    return v;
`endif
  endfunction

  function automatic logic [5:0] exp_bits(input logic [23:0] w, input logic [3:0] p);
    return {gam(w[23:20]) > p, gam(w[19:16]) > p, gam(w[15:12]) > p,
            gam(w[11:8])  > p, gam(w[7:4])   > p, gam(w[3:0])   > p};
  endfunction

  task automatic fill_const(input logic [11:0] up, input logic [11:0] lo);
    for (int a = 0; a < (1 << AW); a++) mem[a] = {up, lo};
  endtask

  task automatic fill_ramp();
    // upper R follows column[3:0]; lower G counts down
    for (int a = 0; a < (1 << AW); a++) begin
      logic [3:0] k;
      k = 4'(a);
      mem[a] = {k, 4'h0, 4'h0, 4'h0, 4'hF - k, 4'h0};
    end
  endtask

  task automatic fill_rand();
    for (int a = 0; a < (1 << AW); a++) mem[a] = 24'($urandom);
  endtask

  // Called at a negedge; drives one line request and checks the whole line.
  task automatic run_line(input logic [ROW_W-1:0] row, input logic [3:0] pwm,
                          input int glitch_at, input int rst_at);
    int   edges, dones, done_at;
    bit   aborted;
    logic prev_sclk;
    logic [5:0] e;
    edges = 0; dones = 0; done_at = -1; aborted = 0; prev_sclk = 1'b0;
    line.next_line_begin = 1'b1;
    line.next_line_addr  = row;
    line.next_line_pwm   = pwm;
    @(negedge clk_25MHz);
    line.next_line_addr  = ~row;
    line.next_line_pwm   = ~pwm;
    for (int n = 1; n <= 140; n++) begin
      line.next_line_begin = (n == glitch_at);
      if (!aborted) begin
        if ((n % 2 == 1) && (n <= 2 * COLS - 1))
          check("ram_addr", 32'(ram_addr), 32'({row, COL_W'((n - 1) / 2)}));
        if (sclk && !prev_sclk) begin
          e = exp_bits(mem[{row, COL_W'(edges)}], pwm);
          check("rgb1", 32'(rgb1), 32'(e[5:3]));
          check("rgb2", 32'(rgb2), 32'(e[2:0]));
          check("edge_time", 32'(n), 32'(4 + 2 * edges));
          edges++;
        end
      end
      if (line.next_line_done) begin
        dones++;
        done_at = n;
      end
      prev_sclk = sclk;
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_outputs", 32'({sclk, rgb1, rgb2, line.next_line_done, ram_addr}), 32'd0);
        aborted = 1;
      end
      if (n == rst_at + 1) rst = 1'b0;
      @(negedge clk_25MHz);
    end
    line.next_line_begin = 1'b0;
    if (aborted) begin
      check("done_after_abort", 32'(dones), 32'd0);
    end else begin
      check("edge_count", 32'(edges), 32'(COLS));
      check("done_time", 32'(done_at), 32'(3 + 2 * COLS));
      check("done_count", 32'(dones), 32'd1);
    end
  endtask

  initial begin
    line.next_line_begin = 1'b0;
    line.next_line_addr  = '0;
    line.next_line_pwm   = '0;
    fill_const(12'h000, 12'h000);
    repeat (3) @(negedge clk_25MHz);
    check("reset_outputs", 32'({sclk, rgb1, rgb2, line.next_line_done, ram_addr}), 32'd0);
    rst = 1'b0;
    @(negedge clk_25MHz);

    run_line(5'd3, 4'd0, -1, -1);

    fill_const(12'hF00, 12'h0F0);
    run_line(5'd5, 4'd14, -1, -1);
    run_line(5'd5, 4'd15, -1, -1);

    fill_ramp();
    run_line(5'd7, 4'd7, -1, -1);

    fill_rand();
    run_line(5'd2, 4'd3, 50, -1);
    run_line(5'd1, 4'd9, -1, 40);
    run_line(5'd9, 4'd9, -1, -1);
    // begin arriving during the done cycle must be ignored
    run_line(5'd30, 4'd5, 131, -1);
    check("begin_at_done_ignored", 32'(ram_addr), 32'({5'd30, COL_W'(COLS - 1)}));
    run_line(5'd31, 4'd0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/led_line_shifter.md
# led_line_shifter

Line-shift responder for the HUB75 LED matrix datapath. When the row/PWM sequencer pulses `next_line_begin`, the block fetches one row pair of RGB444 pixels from the framebuffer RAM and compares each channel against the current PWM threshold. It shifts the resulting on/off bits out on `rgb1`/`rgb2` with a panel shift clock, then answers with a single-cycle `next_line_done`. The sequencer then blanks, latches and advances the row.

## Interface
Parameters:
- `COLS`, 64: columns per row; must be a power of two, at least 2.
- `COL_W`, 6: column index width, equal to log2(`COLS`).
- `ROW_W`, 5: row address width.

Ports:
- `clk_25MHz`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `next_line_begin`, in, 1: one-cycle start pulse from the sequencer.
- `next_line_addr`, in, `ROW_W`: row pair to shift; sampled with `next_line_begin`.
- `next_line_pwm`, in, 4: PWM threshold 0..15; sampled with `next_line_begin`.
- `next_line_done`, out, 1: one-cycle pulse after the last column's rising shift edge.
- `ram_addr`, out, `ROW_W`+`COL_W`: framebuffer read address, formed as {row, col}.
- `ram_rdata`, in, 24: [23:12] is upper-half RGB444 (R[23:20] G[19:16] B[15:12]); [11:0] is lower-half RGB444. Read latency is 1 cycle.
- `sclk`, out, 1: panel shift clock; the panel samples on the rising edge.
- `rgb1`, out, 3: upper-half {R,G,B} bits.
- `rgb2`, out, 3: lower-half {R,G,B} bits.

## Operation
- States: `S_IDLE`, `S_PREFETCH`, `S_SETUP` (sclk low, data driven), `S_CLKHI` (sclk high), `S_DONE`.
- In `S_IDLE` with `next_line_begin`=1:
  - Latch row and pwm into registers.
  - Set `col`=0 and drive `ram_addr`={row,0}.
  - Go to `S_PREFETCH`.
- `S_PREFETCH`: wait one cycle for read data, then go to `S_SETUP`.
- `S_SETUP`:
  - Register the compare result onto `rgb1`/`rgb2`, with `sclk`=0.
  - Channel bit = (channel intensity > latched pwm). Compare is 4-bit unsigned strict greater-than, so intensity 0 is always off and intensity 15 is on for pwm 0..14.
  - Drive `ram_addr` with col+1, prefetching the next column (held when col=`COLS`-1).
  - Go to `S_CLKHI`.
- `S_CLKHI`:
  - Drive `sclk`=1; `rgb` is held.
  - If col=`COLS`-1, go to `S_DONE`; otherwise col+1 and go to `S_SETUP`.
- `S_DONE`: `next_line_done`=1 and `sclk`=0 for exactly one cycle, then `S_IDLE`.
- `next_line_begin` is ignored in every state except `S_IDLE`; there is no queueing.
- The `col` counter is `COL_W` bits and its terminal value is `COLS`-1; it never wraps mid-line.
- Row and pwm are latched values; input changes during a line have no effect.

## Timing
- Reset values: `sclk`=0, `rgb1`=0, `rgb2`=0, `next_line_done`=0, `ram_addr`=0, state `S_IDLE`, col=0.
- Reset asserted mid-line aborts the line immediately and asynchronously; no `next_line_done` is produced.
- Begin sampled at cycle T:
  - `ram_addr` for col 0 is valid at T+1.
  - Column k data is valid at T+3+2k; its `sclk` rising edge is at T+4+2k.
  - `next_line_done` is at T+3+2·`COLS`: T+131 for `COLS`=64.
- `rgb` is stable for the full `sclk`-high cycle plus one setup cycle. Shift clock is 12.5 MHz with a 50% duty cycle.
- The earliest next begin is accepted at T+4+2·`COLS`, i.e. one cycle after done.

## Configuration
- `LED_LINE_GAMMA_EN` defined: each 4-bit channel passes through a fixed 16-entry gamma LUT before the compare. The LUT is combinational and adds no cycles.
  - Required entries: 0→0, 15→15, monotonic non-decreasing.
- `LED_LINE_GAMMA_EN` undefined: raw intensity is compared directly; the LUT is absent.

## Structure
- Shared package `led_matrix_pkg` holds:
  - the state encoding constants;
  - RGB444 field offsets (R/G/B high and low bit positions, upper/lower half base);
  - the default `COLS`, `COL_W` and `ROW_W` values.
- Sub-module: `led_gamma_lut` (4-bit in, 4-bit out). It is instantiated six times, only under `LED_LINE_GAMMA_EN`.

## Test plan
- Reset, begin with row=3 and pwm=0, RAM all 0x000_000:
  - `ram_addr` runs 0xC0..0xFF.
  - 64 `sclk` rising edges occur with `rgb1`=`rgb2`=0.
  - `next_line_done` fires at T+131.
- Upper word 0xF00 and lower word 0x0F0 for all columns, pwm=14: `rgb1`=100 and `rgb2`=010 on every edge. With pwm=15, both are 000.
- Column k upper R = k[3:0], pwm=7: `rgb1`[2]=1 exactly for columns where k mod 16 > 7 (8 of every 16).
- Begin pulsed again at T+50 during a line: ignored. `ram_addr` sequence and done timing are unchanged, and exactly one done pulse occurs.
- `rst` asserted at T+40: all outputs become 0 within the same cycle and no done pulse appears. A new begin after release completes normally.
- With `LED_LINE_GAMMA_EN`, intensity 15 at pwm=14 gives on, and intensity 0 at pwm=0 gives off. Mid-scale outputs match the LUT contents.
